// File: rtl/spiw_pkg.sv
// Shared types and helpers for the multi-channel SPI DAC writer.
package spiw_pkg;

   typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_e;

   function automatic int CH_W(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spiw_tick_gen.sv
// Half-period tick generator: counts 0..DIV-1 while enabled, ticking on DIV-1.
module spiw_tick_gen #(
   parameter int DIV = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = en_i && (cnt_q == CNT_W'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spiw_multich.sv
// SPI write controller: sends one CS-framed word per enabled channel, lowest channel first.
module spiw_multich
   import spiw_pkg::*;
#(
   parameter int DW   = 16,
   parameter int NCH  = 2,
   parameter int DIV  = 4,
   parameter bit CPOL = 1'b0,
   parameter bit CPHA = 1'b0,
   parameter int CSH  = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  strw_i,
   input  logic [NCH-1:0]        chen_i,
   input  logic [NCH*DW-1:0]     data_i,
   output logic                  cs_o,
   output logic                  sck_o,
   output logic                  mosi_o,
   output logic [CH_W(NCH)-1:0]  ch_o,
   output logic                  busy_o,
   output logic                  eow_o
);

   localparam int CW = CH_W(NCH);
   localparam int BW = $clog2(DW);
   localparam int GW = (CSH > 1) ? $clog2(CSH) : 1;

   state_e            st_q, st_d;
   logic [NCH-1:0]    chen_q, chen_d;
   logic [NCH*DW-1:0] data_q, data_d;
   logic [DW-1:0]     sh_q, sh_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic              ph_q, ph_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic [CW-1:0]     ch_q, ch_d;
   logic              cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
   logic              busy_q, busy_d, eow_q, eow_d;

   logic              tick, tick_clr, load, shift, nxt_vld;
   logic [CW-1:0]     first_ch, nxt_ch;
   logic [DW-1:0]     load_word;

   spiw_tick_gen #(.DIV(DIV)) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (tick_clr),
      .en_i   (st_q != IDLE),
      .tick_o (tick)
   );

   // Channel scan: lowest requested channel on start, next enabled one above ch_q afterwards.
   always_comb begin
      first_ch = '0;
      nxt_ch   = '0;
      nxt_vld  = 1'b0;
      for (int k = NCH - 1; k >= 0; k--) begin
         if (chen_i[k]) first_ch = CW'(k);
         if (chen_q[k] && (k > int'(ch_q))) begin
            nxt_vld = 1'b1;
            nxt_ch  = CW'(k);
         end
      end
   end

   always_comb begin
      st_d      = st_q;
      chen_d    = chen_q;
      data_d    = data_q;
      sh_d      = sh_q;
      bit_d     = bit_q;
      ph_d      = ph_q;
      gap_d     = gap_q;
      ch_d      = ch_q;
      cs_d      = cs_q;
      sck_d     = sck_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      eow_d     = 1'b0;
      tick_clr  = 1'b0;
      load      = 1'b0;
      shift     = 1'b0;
      load_word = data_q[int'(nxt_ch)*DW +: DW];
      case (st_q)
         IDLE: begin
            if (strw_i) begin
               if (|chen_i) begin
                  st_d      = LEAD;
                  chen_d    = chen_i;
                  data_d    = data_i;
                  ch_d      = first_ch;
                  load      = 1'b1;
                  load_word = data_i[int'(first_ch)*DW +: DW];
                  cs_d      = 1'b0;
                  busy_d    = 1'b1;
                  tick_clr  = 1'b1;
               end else begin
                  eow_d = 1'b1;
               end
            end
         end
         LEAD: begin
            if (tick) begin
               st_d  = XFER;
               sck_d = ~CPOL;
               ph_d  = 1'b0;
               bit_d = '0;
               shift = CPHA;
            end
         end
         // ph_q = 0 is the leading half of a bit, ph_q = 1 the trailing half.
         XFER: begin
            if (tick) begin
               if (!ph_q) begin
                  sck_d = CPOL;
                  ph_d  = 1'b1;
                  shift = !CPHA && (bit_q != BW'(DW - 1));
               end else if (bit_q == BW'(DW - 1)) begin
                  st_d = TRAIL;
               end else begin
                  sck_d = ~CPOL;
                  ph_d  = 1'b0;
                  bit_d = bit_q + 1'b1;
                  shift = CPHA;
               end
            end
         end
         TRAIL: begin
            if (tick) begin
               st_d  = GAP;
               cs_d  = 1'b1;
               gap_d = '0;
            end
         end
         GAP: begin
            if (tick) begin
               if (gap_q != GW'(CSH - 1)) begin
                  gap_d = gap_q + 1'b1;
               end else if (nxt_vld) begin
                  st_d     = LEAD;
                  ch_d     = nxt_ch;
                  load     = 1'b1;
                  cs_d     = 1'b0;
                  tick_clr = 1'b1;
               end else begin
                  st_d   = IDLE;
                  busy_d = 1'b0;
                  eow_d  = 1'b1;
               end
            end
         end
         default: st_d = IDLE;
      endcase
      // In mode CPHA=0 the MSB must already sit on MOSI before the first leading edge.
      if (load) begin
         if (CPHA) begin
            sh_d = load_word;
         end else begin
            sh_d   = load_word << 1;
            mosi_d = load_word[DW-1];
         end
      end else if (shift) begin
         sh_d   = sh_q << 1;
         mosi_d = sh_q[DW-1];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         st_q   <= IDLE;
         chen_q <= '0;
         data_q <= '0;
         sh_q   <= '0;
         bit_q  <= '0;
         ph_q   <= 1'b0;
         gap_q  <= '0;
         ch_q   <= '0;
         cs_q   <= 1'b1;
         sck_q  <= CPOL;
         mosi_q <= 1'b0;
         busy_q <= 1'b0;
         eow_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         chen_q <= chen_d;
         data_q <= data_d;
         sh_q   <= sh_d;
         bit_q  <= bit_d;
         ph_q   <= ph_d;
         gap_q  <= gap_d;
         ch_q   <= ch_d;
         cs_q   <= cs_d;
         sck_q  <= sck_d;
         mosi_q <= mosi_d;
         busy_q <= busy_d;
         eow_q  <= eow_d;
      end
   end

   assign cs_o   = cs_q;
   assign sck_o  = sck_q;
   assign mosi_o = mosi_q;
   assign ch_o   = ch_q;
   assign busy_o = busy_q;
   assign eow_o  = eow_q;

endmodule

// File: tb/tb_spiw_multich.sv
// Directed bench for spiw_multich: a 2-channel mode-0 writer, the four SPI modes and a sparse 4-channel mask.
module tb_spiw_multich;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic mon_clr = 1'b0;
   int   nvec = 0;
   int   nerr = 0;

   always #5 clk = ~clk;

   // Main instance: DW=16, NCH=2, DIV=4, mode 0, CSH=2.
   logic        strw0 = 1'b0;
   logic [1:0]  chen0 = '0;
   logic [31:0] data0 = '0;
   logic        cs0, sck0, mosi0, busy0, eow0;
   logic [0:0]  ch0;

   spiw_multich #(.DW(16), .NCH(2), .DIV(4), .CPOL(1'b0), .CPHA(1'b0), .CSH(2)) u_dut0 (
      .clk_i(clk), .rst_i(rst), .strw_i(strw0), .chen_i(chen0), .data_i(data0),
      .cs_o(cs0), .sck_o(sck0), .mosi_o(mosi0), .ch_o(ch0), .busy_o(busy0), .eow_o(eow0)
   );

   // Frame recorder for the main instance: CS-low/high lengths, words sampled on SCK rise, channel at frame start.
   int          lowcnt0 = 0, highcnt0 = 0, nf0 = 0, busycnt0 = 0, eowcnt0 = 0, gap0 = 0;
   bit          eab0 = 1'b0;
   logic [15:0] rxw0 = '0;
   int          flen0 [4];
   logic [15:0] fw0 [4];
   logic [0:0]  fch0 [4];
   logic        cs0_p = 1'b1, sck0_p = 1'b0, busy0_p = 1'b0;

   always @(negedge clk) begin
      if (mon_clr) begin
         nf0 = 0; busycnt0 = 0; eowcnt0 = 0; eab0 = 1'b0; gap0 = 0;
      end
      if (cs0 === 1'b0) begin
         if (cs0_p === 1'b1) begin
            lowcnt0 = 0;
            rxw0 = '0;
            if (nf0 < 4) fch0[nf0] = ch0;
            if (nf0 > 0) gap0 = highcnt0;
         end
         lowcnt0++;
         if (sck0 === 1'b1 && sck0_p === 1'b0) rxw0 = {rxw0[14:0], mosi0};
      end else begin
         if (cs0_p === 1'b0) begin
            if (nf0 < 4) begin
               flen0[nf0] = lowcnt0;
               fw0[nf0] = rxw0;
            end
            nf0++;
            highcnt0 = 0;
         end
         highcnt0++;
      end
      if (busy0 === 1'b1) busycnt0++;
      if (eow0 === 1'b1) begin
         eowcnt0++;
         eab0 = (busy0_p === 1'b1) && (busy0 === 1'b0);
      end
      cs0_p = cs0; sck0_p = sck0; busy0_p = busy0;
   end

   // Four single-channel instances covering every CPOL/CPHA pair, each with a DAC-side sampler.
   logic strwm = 1'b0;

   for (genvar m = 0; m < 4; m++) begin : g_m
      localparam bit POL = bit'(m / 2);
      localparam bit PHA = bit'(m % 2);
      localparam bit TGT = POL ^ !PHA;
      logic       cs, sck, mosi, busy, eow;
      logic [0:0] ch;
      logic [7:0] rx = '0;
      int         nbits = 0, idle_bad = 0;
      logic       sck_p = POL;

      spiw_multich #(.DW(8), .NCH(1), .DIV(1), .CPOL(POL), .CPHA(PHA), .CSH(1)) u_dut (
         .clk_i(clk), .rst_i(rst), .strw_i(strwm), .chen_i(1'b1), .data_i(8'h81),
         .cs_o(cs), .sck_o(sck), .mosi_o(mosi), .ch_o(ch), .busy_o(busy), .eow_o(eow)
      );

      always @(negedge clk) begin
         if (cs === 1'b0 && sck !== sck_p && sck === TGT) begin
            rx = {rx[6:0], mosi};
            nbits++;
         end
         if (cs === 1'b1 && sck !== POL) idle_bad++;
         sck_p = sck;
      end
   end

   // Four-channel instance with a sparse enable mask.
   logic        strw4 = 1'b0;
   logic        cs4, sck4, mosi4, busy4, eow4;
   logic [1:0]  ch4;
   int          nf4 = 0, busycnt4 = 0;
   logic [7:0]  rxw4 = '0;
   logic [7:0]  fw4 [4];
   logic [1:0]  fch4 [4];
   logic        cs4_p = 1'b1, sck4_p = 1'b0;

   spiw_multich #(.DW(8), .NCH(4), .DIV(1), .CPOL(1'b0), .CPHA(1'b0), .CSH(1)) u_dut4 (
      .clk_i(clk), .rst_i(rst), .strw_i(strw4), .chen_i(4'b1010),
      .data_i({8'h44, 8'h33, 8'h22, 8'h11}),
      .cs_o(cs4), .sck_o(sck4), .mosi_o(mosi4), .ch_o(ch4), .busy_o(busy4), .eow_o(eow4)
   );

   always @(negedge clk) begin
      if (cs4 === 1'b0) begin
         if (cs4_p === 1'b1) begin
            rxw4 = '0;
            if (nf4 < 4) fch4[nf4] = ch4;
         end
         if (sck4 === 1'b1 && sck4_p === 1'b0) rxw4 = {rxw4[6:0], mosi4};
      end else if (cs4_p === 1'b0) begin
         if (nf4 < 4) fw4[nf4] = rxw4;
         nf4++;
      end
      if (busy4 === 1'b1) busycnt4++;
      cs4_p = cs4; sck4_p = sck4;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start request on the main instance; returns at the negedge right after the accepting edge.
   task automatic applyStimulus(input logic [1:0] chen, input logic [31:0] data);
      @(negedge clk);
      chen0 = chen;
      data0 = data;
      strw0 = 1'b1;
      @(negedge clk);
      strw0 = 1'b0;
   endtask

   task automatic clearMon();
      @(posedge clk);
      mon_clr = 1'b1;
      @(posedge clk);
      mon_clr = 1'b0;
   endtask

   task automatic waitEow(input int sel, input int maxc);
      bit seen = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (((sel == 0) ? eow0 : eow4) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("eow within budget", 32'(seen), 32'd1);
   endtask

   initial begin
      // Reset values.
      repeat (3) @(negedge clk);
      checkOutput("rst cs", 32'(cs0), 32'd1);
      checkOutput("rst sck", 32'(sck0), 32'd0);
      checkOutput("rst mosi", 32'(mosi0), 32'd0);
      checkOutput("rst ch", 32'(ch0), 32'd0);
      checkOutput("rst busy", 32'(busy0), 32'd0);
      checkOutput("rst eow", 32'(eow0), 32'd0);
      checkOutput("rst sck m2", 32'(g_m[2].sck), 32'd1);
      checkOutput("rst sck m3", 32'(g_m[3].sck), 32'd1);
      rst = 1'b0;

      // Two-channel write, ch0 = A5C3, ch1 = 0F0F.
      clearMon();
      applyStimulus(2'b11, {16'h0F0F, 16'hA5C3});
      checkOutput("A cs after accept", 32'(cs0), 32'd0);
      checkOutput("A busy after accept", 32'(busy0), 32'd1);
      waitEow(0, 400);
      @(negedge clk);
      checkOutput("A eow one cycle", 32'(eow0), 32'd0);
      @(posedge clk);
      checkOutput("A frames", 32'(nf0), 32'd2);
      checkOutput("A len0", 32'(flen0[0]), 32'd136);
      checkOutput("A len1", 32'(flen0[1]), 32'd136);
      checkOutput("A gap", 32'(gap0), 32'd8);
      checkOutput("A word0", 32'(fw0[0]), 32'hA5C3);
      checkOutput("A word1", 32'(fw0[1]), 32'h0F0F);
      checkOutput("A ch0", 32'(fch0[0]), 32'd0);
      checkOutput("A ch1", 32'(fch0[1]), 32'd1);
      checkOutput("A busy cycles", 32'(busycnt0), 32'd288);
      checkOutput("A eow count", 32'(eowcnt0), 32'd1);
      checkOutput("A eow at busy fall", 32'(eab0), 32'd1);

      // Start re-requested mid-frame with different data: must be ignored.
      clearMon();
      applyStimulus(2'b11, {16'h3C3C, 16'h5A5A});
      repeat (60) @(negedge clk);
      applyStimulus(2'b01, 32'hFFFF_FFFF);
      waitEow(0, 400);
      @(posedge clk);
      checkOutput("B frames", 32'(nf0), 32'd2);
      checkOutput("B word0", 32'(fw0[0]), 32'h5A5A);
      checkOutput("B word1", 32'(fw0[1]), 32'h3C3C);
      checkOutput("B busy cycles", 32'(busycnt0), 32'd288);

      // Empty channel mask: eow only, no frame.
      clearMon();
      applyStimulus(2'b00, 32'h1111_2222);
      checkOutput("Z eow", 32'(eow0), 32'd1);
      checkOutput("Z busy", 32'(busy0), 32'd0);
      checkOutput("Z cs", 32'(cs0), 32'd1);
      @(negedge clk);
      checkOutput("Z eow drop", 32'(eow0), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("Z no frame", 32'(nf0), 32'd0);

      // Reset during XFER bit 5, then a clean single-channel write.
      applyStimulus(2'b11, {16'hFFFF, 16'hFFFF});
      repeat (45) @(negedge clk);
      checkOutput("R cs low before reset", 32'(cs0), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("R cs", 32'(cs0), 32'd1);
      checkOutput("R sck", 32'(sck0), 32'd0);
      checkOutput("R busy", 32'(busy0), 32'd0);
      checkOutput("R eow", 32'(eow0), 32'd0);
      checkOutput("R mosi", 32'(mosi0), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      clearMon();
      applyStimulus(2'b01, {16'hFFFF, 16'h1234});
      waitEow(0, 400);
      @(posedge clk);
      checkOutput("R frames", 32'(nf0), 32'd1);
      checkOutput("R word", 32'(fw0[0]), 32'h1234);
      checkOutput("R len", 32'(flen0[0]), 32'd136);
      checkOutput("R busy cycles", 32'(busycnt0), 32'd144);

      // All four SPI modes on 0x81.
      @(negedge clk);
      strwm = 1'b1;
      @(negedge clk);
      strwm = 1'b0;
      repeat (30) @(negedge clk);
      @(posedge clk);
      checkOutput("m0 word", 32'(g_m[0].rx), 32'h81);
      checkOutput("m0 bits", 32'(g_m[0].nbits), 32'd8);
      checkOutput("m0 idle", 32'(g_m[0].idle_bad), 32'd0);
      checkOutput("m1 word", 32'(g_m[1].rx), 32'h81);
      checkOutput("m1 bits", 32'(g_m[1].nbits), 32'd8);
      checkOutput("m1 idle", 32'(g_m[1].idle_bad), 32'd0);
      checkOutput("m2 word", 32'(g_m[2].rx), 32'h81);
      checkOutput("m2 bits", 32'(g_m[2].nbits), 32'd8);
      checkOutput("m2 idle", 32'(g_m[2].idle_bad), 32'd0);
      checkOutput("m3 word", 32'(g_m[3].rx), 32'h81);
      checkOutput("m3 bits", 32'(g_m[3].nbits), 32'd8);
      checkOutput("m3 idle", 32'(g_m[3].idle_bad), 32'd0);

      // Sparse mask 1010 on four channels: channels 1 then 3.
      @(negedge clk);
      strw4 = 1'b1;
      @(negedge clk);
      strw4 = 1'b0;
      waitEow(4, 200);
      @(posedge clk);
      checkOutput("S frames", 32'(nf4), 32'd2);
      checkOutput("S ch first", 32'(fch4[0]), 32'd1);
      checkOutput("S ch second", 32'(fch4[1]), 32'd3);
      checkOutput("S word first", 32'(fw4[0]), 32'h22);
      checkOutput("S word second", 32'(fw4[1]), 32'h44);
      checkOutput("S busy cycles", 32'(busycnt4), 32'd38);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
